// File: rtl/wb_stage_seq_pkg.sv
// Shared constants for the registered write-back stage: load size codes,
// sequencing states and the default datapath width.
package wb_stage_seq_pkg;

    localparam int WORD_W_DEF = 32;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of the
// aligned memory word, extends it, and flags odd-address half-word loads.
module wb_load_align
    import wb_stage_seq_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic [WORD_W-1:0] mem_result,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [1:0]        addr_lo,
    output logic [WORD_W-1:0] ext_data,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = mem_result[7:0];
        half_sel   = mem_result[15:0];
        ext_data   = mem_result;
        misaligned = 1'b0;

        case (addr_lo)
            2'd0:    byte_sel = mem_result[7:0];
            2'd1:    byte_sel = mem_result[15:8];
            2'd2:    byte_sel = mem_result[23:16];
            default: byte_sel = mem_result[31:24];
        endcase

        // Only addr_lo[1] selects the half; addr_lo[0] marks the access misaligned.
        half_sel = addr_lo[1] ? mem_result[31:16] : mem_result[15:0];

        case (mem_size)
            MEM_B: ext_data = {{(WORD_W-8){~mem_unsigned & byte_sel[7]}}, byte_sel};
            MEM_H: begin
                ext_data   = {{(WORD_W-16){~mem_unsigned & half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            MEM_W:   ext_data = mem_result;
            default: ext_data = mem_result;
        endcase
    end

endmodule

// File: rtl/wb_stage_seq.sv
// Registered write-back stage: drives the register-file write port and
// forwarding bus one cycle after accept, counts retires, and sequences halt.
//   state    | meaning
//   ST_RUN   | accepting bundles, in_ready=1
//   ST_DRAIN | terminate seen, counting out DRAIN_CYC cycles, inputs ignored
//   ST_HALT  | drain complete, halted=1 until reset
module wb_stage_seq
    import wb_stage_seq_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_r,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] mem_result,
    input  logic [WORD_W-1:0] alu_result,
    input  logic              reg_w,
    input  logic [REG_AW-1:0] rd,
    input  logic              terminate,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [WORD_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic              align_err,
    output logic              halted,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);

    wb_state_e          state_q, state_d;
    logic [DCNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic               rf_we_q, rf_we_d;
    logic [REG_AW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [WORD_W-1:0]  rf_wdata_q, rf_wdata_d;
    logic               align_err_q, align_err_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

    logic               accept;
    logic               ld_mis;
    logic               mis;
    logic [WORD_W-1:0]  ld_data;
    logic [WORD_W-1:0]  wb_data;

    wb_load_align #(
        .WORD_W (WORD_W)
    ) u_align (
        .mem_result   (mem_result),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr_lo      (addr_lo),
        .ext_data     (ld_data),
        .misaligned   (ld_mis)
    );

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        align_err_d  = align_err_q;
        retire_cnt_d = retire_cnt_q;

        in_ready = (state_q == ST_RUN);
        accept   = in_valid & in_ready;
        mis      = mem_r & ld_mis;
        wb_data  = mem_r ? ld_data : alu_result;

        if (accept) begin
            rf_we_d    = reg_w & (rd != '0) & ~mis;
            rf_waddr_d = rd;
            rf_wdata_d = wb_data;
            if (mis) begin
                align_err_d = 1'b1;
            end
            if (retire_cnt_q != '1) begin
                retire_cnt_d = retire_cnt_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (accept && terminate) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            align_err_q  <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            align_err_q  <= align_err_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign fwd_valid  = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign align_err  = align_err_q;
    assign halted     = (state_q == ST_HALT);
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_seq.sv
// Randomized bench for wb_stage_seq: a cycle-indexed reference model plus
// directed cases, with a second CNT_W=4 instance for counter saturation.
module tb_wb_stage_seq;

    localparam int D = 4;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        in_valid     = 1'b0;
    logic        mem_r        = 1'b0;
    logic [1:0]  mem_size     = 2'b00;
    logic        mem_unsigned = 1'b0;
    logic [1:0]  addr_lo      = 2'b00;
    logic [31:0] mem_result   = 32'h0;
    logic [31:0] alu_result   = 32'h0;
    logic        reg_w        = 1'b0;
    logic [4:0]  rd           = 5'd0;
    logic        terminate    = 1'b0;

    logic        in_ready, rf_we, fwd_valid, align_err, halted;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] retire_cnt;

    logic        s_in_ready, s_rf_we, s_fwd_valid, s_align_err, s_halted;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata;
    logic [3:0]  s_retire_cnt;

    wb_stage_seq #(.WORD_W(32), .REG_AW(5), .CNT_W(32), .DRAIN_CYC(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mem_r(mem_r), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .addr_lo(addr_lo), .mem_result(mem_result), .alu_result(alu_result),
        .reg_w(reg_w), .rd(rd), .terminate(terminate),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .align_err(align_err), .halted(halted),
        .retire_cnt(retire_cnt)
    );

    wb_stage_seq #(.WORD_W(32), .REG_AW(5), .CNT_W(4), .DRAIN_CYC(D)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .mem_r(mem_r), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .addr_lo(addr_lo), .mem_result(mem_result), .alu_result(alu_result),
        .reg_w(reg_w), .rd(rd), .terminate(terminate),
        .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
        .fwd_valid(s_fwd_valid), .align_err(s_align_err), .halted(s_halted),
        .retire_cnt(s_retire_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // model: edges since reset, edge of the terminating accept (-1 = none)
    int          cyc    = 0;
    int          term_e = -1;
    logic        m_we   = 1'b0;
    logic [4:0]  m_waddr = 5'd0;
    logic [31:0] m_wdata = 32'h0;
    logic        m_align = 1'b0;
    longint      m_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_wb(input logic mr, input logic [1:0] sz, input logic un,
                                           input logic [1:0] al, input logic [31:0] mres,
                                           input logic [31:0] alu);
        logic [31:0] v;
        if (!mr) return alu;
        if (sz == 2'd0) begin
            v = (mres >> (8 * int'(al))) & 32'hFF;
            if (!un && v >= 32'd128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (sz == 2'd1) begin
            v = (mres >> (16 * (int'(al) / 2))) & 32'hFFFF;
            if (!un && v >= 32'd32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return mres;
    endfunction

    task automatic model_update();
        logic mis;
        if (!rst_n) begin
            cyc = 0; term_e = -1; m_we = 1'b0; m_waddr = 5'd0;
            m_wdata = 32'h0; m_align = 1'b0; m_cnt = 0;
        end else begin
            logic ready;
            ready = (term_e < 0);
            cyc++;
            if (in_valid && ready) begin
                mis     = mem_r && (mem_size == 2'd1) && (addr_lo % 2 == 1);
                m_we    = reg_w && (rd != 5'd0) && !mis;
                m_waddr = rd;
                m_wdata = ref_wb(mem_r, mem_size, mem_unsigned, addr_lo, mem_result, alu_result);
                if (mis) m_align = 1'b1;
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (terminate) term_e = cyc;
            end else begin
                m_we = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        logic exp_ready, exp_halt;
        exp_ready = (term_e < 0);
        exp_halt  = (term_e >= 0) && (cyc - term_e >= D);
        chk("in_ready",   in_ready,   exp_ready);
        chk("rf_we",      rf_we,      m_we);
        chk("fwd_valid",  fwd_valid,  m_we);
        chk("rf_waddr",   rf_waddr,   m_waddr);
        chk("rf_wdata",   rf_wdata,   m_wdata);
        chk("align_err",  align_err,  m_align);
        chk("halted",     halted,     exp_halt);
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("s_in_ready", s_in_ready, exp_ready);
        chk("s_rf_we",    s_rf_we,    m_we);
        chk("s_fwd",      s_fwd_valid, m_we);
        chk("s_rf_waddr", s_rf_waddr, m_waddr);
        chk("s_rf_wdata", s_rf_wdata, m_wdata);
        chk("s_align",    s_align_err, m_align);
        chk("s_halted",   s_halted,   exp_halt);
        chk("s_retire",   s_retire_cnt, (m_cnt > 15) ? 15 : m_cnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_update();
        check_all();
    endtask

    task automatic drive(input logic v, input logic mr, input logic [1:0] sz, input logic un,
                         input logic [1:0] al, input logic [31:0] mres, input logic [31:0] alu,
                         input logic rw, input logic [4:0] r, input logic term);
        in_valid = v; mem_r = mr; mem_size = sz; mem_unsigned = un; addr_lo = al;
        mem_result = mres; alu_result = alu; reg_w = rw; rd = r; terminate = term;
    endtask

    initial begin
        logic [31:0] cnt_hold;

        // reset
        drive(1, 0, 2'd0, 0, 2'd0, 32'h0, 32'hDEAD, 1, 5'd9, 1);
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("rst_ready", in_ready, 1);
        chk("rst_cnt", retire_cnt, 0);
        rst_n = 1'b1;

        // ALU write
        drive(1, 0, 2'd0, 0, 2'd0, 32'h0, 32'h1234, 1, 5'd5, 0);
        cycle();
        chk("t1_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'h1234);
        chk("t1_cnt", retire_cnt, 1);

        // loads
        drive(1, 1, 2'd0, 0, 2'd3, 32'h80FF7F01, 32'h0, 1, 5'd7, 0);
        cycle();
        chk("t2_lb", rf_wdata, 32'hFFFFFF80);
        drive(1, 1, 2'd0, 1, 2'd3, 32'h80FF7F01, 32'h0, 1, 5'd7, 0);
        cycle();
        chk("t2_lbu", rf_wdata, 32'h00000080);
        drive(1, 1, 2'd1, 0, 2'd2, 32'h80FF7F01, 32'h0, 1, 5'd7, 0);
        cycle();
        chk("t2_lh", rf_wdata, 32'hFFFF80FF);
        drive(1, 1, 2'd2, 0, 2'd1, 32'h80FF7F01, 32'h0, 1, 5'd7, 0);
        cycle();
        chk("t2_lw", rf_wdata, 32'h80FF7F01);
        drive(1, 1, 2'd0, 0, 2'd1, 32'h80FF7F01, 32'h0, 1, 5'd7, 0);
        cycle();
        chk("t2_lb1", rf_wdata, 32'h0000007F);

        // misaligned half
        drive(1, 1, 2'd1, 0, 2'd1, 32'h80FF7F01, 32'h0, 1, 5'd3, 0);
        cycle();
        chk("t3_we", rf_we, 0);
        chk("t3_align", align_err, 1);
        chk("t3_cnt", retire_cnt, 7);

        // rd=0 then back-to-back writes
        drive(1, 0, 2'd0, 0, 2'd0, 32'h0, 32'h55, 1, 5'd0, 0);
        cycle();
        chk("t4_rd0", rf_we, 0);
        chk("t4_align_sticky", align_err, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 2'd0, 0, 2'd0, 32'h0, 32'h100 + i, 1, 5'(10 + i), 0);
            cycle();
            chk("t4_b2b_we", rf_we, 1);
            chk("t4_b2b_data", rf_wdata, 32'h100 + i);
        end

        // enough accepts to saturate the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 2'd0, 0, 2'd0, 32'h0, $urandom, 1, 5'($urandom_range(1, 31)), 0);
            cycle();
        end
        chk("sat", s_retire_cnt, 15);

        // terminate and drain
        drive(1, 0, 2'd0, 0, 2'd0, 32'h0, 32'h7, 1, 5'd2, 1);
        cycle();
        chk("t5_we", rf_we, 1);
        chk("t5_waddr", rf_waddr, 2);
        chk("t5_ready", in_ready, 0);
        cnt_hold = retire_cnt;
        for (int i = 1; i <= D + 3; i++) begin
            drive(1, 0, 2'd0, 0, 2'd0, 32'h0, $urandom, 1, 5'd4, 1);
            cycle();
            chk("t5_nowe", rf_we, 0);
            chk("t5_halt", halted, (i >= D) ? 1 : 0);
            chk("t5_cnt", retire_cnt, cnt_hold);
        end

        // reset mid-drain
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        drive(1, 0, 2'd0, 0, 2'd0, 32'h0, 32'h9, 1, 5'd6, 1);
        cycle();
        drive(0, 0, 2'd0, 0, 2'd0, 32'h0, 32'h0, 0, 5'd0, 0);
        cycle();
        rst_n = 1'b0;
        drive(1, 0, 2'd0, 0, 2'd0, 32'h0, 32'hA, 1, 5'd8, 0);
        cycle();
        chk("t6_ready", in_ready, 1);
        chk("t6_we", rf_we, 0);
        chk("t6_wdata", rf_wdata, 0);
        chk("t6_cnt", retire_cnt, 0);
        chk("t6_halt", halted, 0);
        rst_n = 1'b1;

        // random traffic with occasional terminate and reset
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  $urandom_range(0, 29) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
